// File: rtl/apu_pkg.sv
// Shared types and address window for the APU register write path.
// Pure declarations: no logic, no latency, no flow control.
package apu_pkg;

    localparam logic [15:0] APU_REG_FIRST = 16'h4000;
    localparam logic [15:0] APU_REG_LAST  = 16'h4017;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } apu_wr_t;

    function automatic logic apu_addr_in_range(input logic [15:0] addr);
        return (addr >= APU_REG_FIRST) && (addr <= APU_REG_LAST);
    endfunction

endpackage

// File: rtl/apu_wr_fifo.sv
// Synchronous FIFO of apu_wr_t; a pushed entry is visible at the head one cycle later.
// Caller must only push when !full and pop when !empty; flush clears pointers and count.
module apu_wr_fifo
    import apu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  apu_wr_t                    push_dat,
    input  logic                       pop,
    input  logic                       flush,
    output apu_wr_t                    head_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    apu_wr_t         mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem_q[wr_ptr_q] <= push_dat;
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/apu_reg_write_arbiter.sv
// Merges CPU and loader writes onto the APU register bus; CPU wins and passes through in 0 cycles.
// Loader writes queue in a FIFO (ld_ready=0 when full/flush/rst) and drain one per idle cpu_clk_en slot.
module apu_reg_write_arbiter
    import apu_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpu_clk_en,
    input  logic [15:0]                   cpu_addr,
    input  logic [7:0]                    cpu_data,
    input  logic                          cpu_en,
    input  logic                          cpu_we,
    input  logic                          ld_valid,
    input  logic [15:0]                   ld_addr,
    input  logic [7:0]                    ld_data,
    output logic                          ld_ready,
    input  logic                          flush,
    output logic [15:0]                   reg_addr,
    output logic [7:0]                    reg_data,
    output logic                          reg_en,
    output logic                          reg_we,
    output logic                          ld_granted,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]              drop_cnt
);

    apu_wr_t        head_dat;
    apu_wr_t        sel_wr;
    logic           fifo_full, fifo_empty;
    logic           cpu_req, fifo_sel, any_sel, in_range, drop;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    assign cpu_req  = cpu_clk_en & cpu_en & cpu_we & ~rst;
    assign fifo_sel = ~cpu_req & cpu_clk_en & ~fifo_empty & ~flush & ~rst;
    assign any_sel  = cpu_req | fifo_sel;
    assign ld_ready = ~fifo_full & ~flush & ~rst;

    always_comb begin
        sel_wr = '0;
        if (cpu_req)       sel_wr = '{addr: cpu_addr, data: cpu_data};
        else if (fifo_sel) sel_wr = head_dat;
    end

    assign in_range = apu_addr_in_range(sel_wr.addr);
    assign drop     = any_sel & ~in_range;

    assign reg_addr   = sel_wr.addr;
    assign reg_data   = sel_wr.data;
    assign reg_en     = any_sel & in_range;
    assign reg_we     = any_sel & in_range;
    assign ld_granted = fifo_sel;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;

    apu_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (ld_valid & ld_ready),
        .push_dat ('{addr: ld_addr, data: ld_data}),
        .pop      (fifo_sel),
        .flush    (flush),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule
